// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// Covers the FSM state, the bus owner and the round-robin pick.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_DMA  = 1'b1
   } owner_t;

   // On a tie the requester that did not own the last transaction wins.
   function automatic owner_t pick_owner(input logic   core_req,
                                         input logic   dma_req,
                                         input owner_t last_owner);
      owner_t pick;
      if (core_req && dma_req)
         pick = (last_owner == OWN_CORE) ? OWN_DMA : OWN_CORE;
      else if (core_req)
         pick = OWN_CORE;
      else
         pick = OWN_DMA;
      return pick;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core load/store path and a DMA/debug master.
// A per-transaction watchdog ends accesses that never see mem_ack and flags an error to the owner.
//
// state | meaning
// IDLE  | waiting for a request; grants on the next edge
// SERVE | mem_req held with latched we/addr/wdata; counting toward timeout
// DONE  | one cycle: completion (and error) presented to the owner
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NBITS   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             core_read,
   input  logic             core_write,
   input  logic [NBITS-1:0] core_addr,
   input  logic [NBITS-1:0] core_wdata,
   output logic [NBITS-1:0] core_rdata,
   output logic             core_busy,
   output logic             core_err,
   input  logic             dma_req,
   input  logic             dma_we,
   input  logic [NBITS-1:0] dma_addr,
   input  logic [NBITS-1:0] dma_wdata,
   output logic [NBITS-1:0] dma_rdata,
   output logic             dma_ack,
   output logic             dma_err,
   output logic             mem_req,
   output logic             mem_we,
   output logic [NBITS-1:0] mem_addr,
   output logic [NBITS-1:0] mem_wdata,
   input  logic [NBITS-1:0] mem_rdata,
   input  logic             mem_ack
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t           state;
   owner_t           owner;
   owner_t           last_owner;
   owner_t           grant;
   logic             lat_we;
   logic [NBITS-1:0] lat_addr;
   logic [NBITS-1:0] lat_wdata;
   logic [NBITS-1:0] rdata;
   logic             err;
   logic [CW-1:0]    cnt;
   logic             core_req;
   logic             done_core;
   logic             done_dma;

   assign core_req = core_read | core_write;
   assign grant    = pick_owner(core_req, dma_req, last_owner);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= OWN_CORE;
         last_owner <= OWN_DMA;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rdata      <= '0;
         err        <= 1'b0;
         cnt        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (core_req || dma_req) begin
                  owner <= grant;
                  cnt   <= '0;
                  state <= SERVE;
                  if (grant == OWN_CORE) begin
                     lat_we    <= core_write;
                     lat_addr  <= core_addr;
                     lat_wdata <= core_wdata;
                  end else begin
                     lat_we    <= dma_we;
                     lat_addr  <= dma_addr;
                     lat_wdata <= dma_wdata;
                  end
               end
            end
            SERVE: begin
               // An ack in the last counted cycle still completes normally.
               if (mem_ack) begin
                  rdata <= mem_rdata;
                  err   <= 1'b0;
                  state <= DONE;
               end else if (cnt == CNT_LAST) begin
                  rdata <= '0;
                  err   <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               last_owner <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Completion is decoded from registers only; reset suppresses a pending pulse.
   assign done_core = !reset && (state == DONE) && (owner == OWN_CORE);
   assign done_dma  = !reset && (state == DONE) && (owner == OWN_DMA);

   assign mem_req   = (state == SERVE);
   assign mem_we    = lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

   assign core_busy  = core_req & !done_core;
   assign core_rdata = rdata;
   assign core_err   = done_core & err;

   assign dma_ack   = done_dma;
   assign dma_rdata = rdata;
   assign dma_err   = done_dma & err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory model with programmable ack delay
// and a queue of expected transactions checked as each one completes.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int NBITS   = 8;
   localparam int TIMEOUT = 15;

   logic             clock = 1'b0;
   logic             reset;
   logic             core_read, core_write;
   logic [NBITS-1:0] core_addr, core_wdata, core_rdata;
   logic             core_busy, core_err;
   logic             dma_req, dma_we;
   logic [NBITS-1:0] dma_addr, dma_wdata, dma_rdata;
   logic             dma_ack, dma_err;
   logic             mem_req, mem_we;
   logic [NBITS-1:0] mem_addr, mem_wdata, mem_rdata;
   logic             mem_ack;
   logic             model_ack;
   logic             stray_ack;

   int ack_delay;
   int n_checks;
   int n_fail;

   typedef struct {
      logic       is_dma;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      logic       err;
   } txn_t;

   txn_t sb[$];

   always #5 clock = ~clock;

   assign mem_ack = model_ack | stray_ack;

   mem_arbiter #(.NBITS(NBITS), .TIMEOUT(TIMEOUT)) dut (
      .clock      (clock),
      .reset      (reset),
      .core_read  (core_read),
      .core_write (core_write),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_busy  (core_busy),
      .core_err   (core_err),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_rdata  (dma_rdata),
      .dma_ack    (dma_ack),
      .dma_err    (dma_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   function automatic logic [7:0] pat(input logic [7:0] a);
      return a ^ 8'hC3;
   endfunction

   // Memory: acks ack_delay cycles into a request (never when negative).
   initial begin
      logic [7:0] mem_array [256];
      int         wait_cnt;
      for (int i = 0; i < 256; i++) mem_array[i] = pat(8'(i));
      mem_array[8'h10] = 8'hA5;
      model_ack = 1'b0;
      mem_rdata = '0;
      wait_cnt  = 0;
      forever begin
         @(negedge clock);
         if (mem_req && !model_ack && ack_delay >= 0 && wait_cnt == ack_delay) begin
            model_ack = 1'b1;
            mem_rdata = mem_array[mem_addr];
            if (mem_we) mem_array[mem_addr] = mem_wdata;
            wait_cnt  = 0;
         end else if (mem_req && !model_ack) begin
            model_ack = 1'b0;
            wait_cnt++;
         end else begin
            model_ack = 1'b0;
            wait_cnt  = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic is_dma, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rdata, input logic err);
      txn_t t;
      t.is_dma = is_dma;
      t.we     = we;
      t.addr   = addr;
      t.wdata  = wdata;
      t.rdata  = rdata;
      t.err    = err;
      sb.push_back(t);
   endtask

   // Runs until the next completion, checking the memory bus while mem_req is high.
   task automatic serve_one(output int nreq, output logic who, output int cyc);
      txn_t e;
      logic done;
      nreq = 0;
      cyc  = 0;
      who  = 1'b0;
      done = 1'b0;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb[0];
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clock);
         cyc++;
         if (mem_req) begin
            nreq++;
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
         end
         if (dma_ack || ((core_read || core_write) && !core_busy)) begin
            done = 1'b1;
            who  = dma_ack;
            chk("owner", 32'(who), 32'(e.is_dma));
            if (who) begin
               if (!e.we) chk("dma_rdata", 32'(dma_rdata), 32'(e.rdata));
               chk("dma_err", 32'(dma_err), 32'(e.err));
            end else begin
               if (!e.we) chk("core_rdata", 32'(core_rdata), 32'(e.rdata));
               chk("core_err", 32'(core_err), 32'(e.err));
            end
         end
      end
      if (!done) chk("serve_budget", 32'd0, 32'd1);
      e = sb.pop_front();
   endtask

   initial begin
      int   nreq, cyc, nserve, di, ci;
      logic who, prev_who;

      n_checks   = 0;
      n_fail     = 0;
      ack_delay  = 0;
      stray_ack  = 1'b0;
      reset      = 1'b1;
      core_read  = 1'b0;
      core_write = 1'b0;
      core_addr  = '0;
      core_wdata = '0;
      dma_req    = 1'b0;
      dma_we     = 1'b0;
      dma_addr   = '0;
      dma_wdata  = '0;

      // Reset values, and core_busy following core_req while in reset
      repeat (2) @(negedge clock);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_dma_ack", 32'(dma_ack), 32'd0);
      chk("rst_dma_err", 32'(dma_err), 32'd0);
      chk("rst_core_err", 32'(core_err), 32'd0);
      chk("rst_core_rdata", 32'(core_rdata), 32'd0);
      chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
      chk("rst_busy_idle", 32'(core_busy), 32'd0);
      core_read = 1'b1;
      #1 chk("rst_busy_req", 32'(core_busy), 32'd1);
      core_read = 1'b0;
      @(negedge clock);

      // Tie right after reset: core write first, then DMA read
      reset      = 1'b0;
      core_write = 1'b1;
      core_addr  = 8'h20;
      core_wdata = 8'h3C;
      dma_req    = 1'b1;
      dma_we     = 1'b0;
      dma_addr   = 8'h40;
      push(1'b0, 1'b1, 8'h20, 8'h3C, 8'h00, 1'b0);
      push(1'b1, 1'b0, 8'h40, 8'h00, pat(8'h40), 1'b0);
      serve_one(nreq, who, cyc);
      core_write = 1'b0;
      serve_one(nreq, who, cyc);
      dma_req = 1'b0;
      @(negedge clock);
      chk("dma_ack_pulse", 32'(dma_ack), 32'd0);

      // Minimum-latency core read with exact cycle-by-cycle stall
      @(negedge clock);
      core_read = 1'b1;
      core_addr = 8'h10;
      #1 chk("c0_busy", 32'(core_busy), 32'd1);
      @(negedge clock);
      chk("c1_busy", 32'(core_busy), 32'd1);
      chk("c1_mem_req", 32'(mem_req), 32'd1);
      chk("c1_mem_addr", 32'(mem_addr), 32'h10);
      chk("c1_mem_we", 32'(mem_we), 32'd0);
      @(negedge clock);
      chk("c2_busy", 32'(core_busy), 32'd0);
      chk("c2_core_rdata", 32'(core_rdata), 32'hA5);
      chk("c2_core_err", 32'(core_err), 32'd0);
      chk("c2_mem_req", 32'(mem_req), 32'd0);
      core_read = 1'b0;
      repeat (2) @(negedge clock);

      // Continuous requests from both: strict alternation, 3 cycles each
      di = 0;
      ci = 0;
      core_read  = 1'b1;
      core_addr  = 8'h50;
      dma_req    = 1'b1;
      dma_we     = 1'b1;
      dma_addr   = 8'h60;
      dma_wdata  = 8'h00;
      for (int i = 0; i < 3; i++) begin
         push(1'b1, 1'b1, 8'(8'h60 + i), 8'(i), 8'h00, 1'b0);
         push(1'b0, 1'b0, 8'(8'h50 + i), 8'h00, pat(8'(8'h50 + i)), 1'b0);
      end
      prev_who = 1'b0;
      for (int k = 0; k < 6; k++) begin
         serve_one(nreq, who, cyc);
         if (k > 0) begin
            chk("alt_owner", 32'(who), 32'(!prev_who));
            chk("alt_cycles", 32'(cyc), 32'd3);
         end
         prev_who = who;
         if (who) begin
            di++;
            if (di < 3) begin
               dma_addr  = 8'(8'h60 + di);
               dma_wdata = 8'(di);
            end else dma_req = 1'b0;
         end else begin
            ci++;
            if (ci < 3) core_addr = 8'(8'h50 + ci);
            else core_read = 1'b0;
         end
      end
      dma_we = 1'b0;
      @(negedge clock);

      // DMA timeout, then a stray ack that must be ignored
      ack_delay = -1;
      dma_req   = 1'b1;
      dma_addr  = 8'h70;
      push(1'b1, 1'b0, 8'h70, 8'h00, 8'h00, 1'b1);
      serve_one(nreq, who, cyc);
      chk("dma_to_req_cycles", 32'(nreq), 32'(TIMEOUT));
      dma_req = 1'b0;
      @(negedge clock);
      stray_ack = 1'b1;
      @(negedge clock);
      stray_ack = 1'b0;
      chk("stray_dma_ack", 32'(dma_ack), 32'd0);
      chk("stray_mem_req", 32'(mem_req), 32'd0);
      @(negedge clock);
      chk("stray_mem_req2", 32'(mem_req), 32'd0);

      // Core timeout: single-cycle error pulse
      core_read = 1'b1;
      core_addr = 8'h90;
      push(1'b0, 1'b0, 8'h90, 8'h00, 8'h00, 1'b1);
      serve_one(nreq, who, cyc);
      chk("core_to_req_cycles", 32'(nreq), 32'(TIMEOUT));
      core_read = 1'b0;
      @(negedge clock);
      chk("core_err_pulse", 32'(core_err), 32'd0);

      // Reset in the third SERVE cycle; the following tie goes to the core
      core_read = 1'b1;
      core_addr = 8'h80;
      nserve    = 0;
      for (int c = 0; c < 50 && nserve < 3; c++) begin
         @(negedge clock);
         if (mem_req) nserve++;
      end
      chk("rst_mid_reached", 32'(nserve), 32'd3);
      reset    = 1'b1;
      dma_req  = 1'b1;
      dma_we   = 1'b0;
      dma_addr = 8'hA0;
      @(negedge clock);
      chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mid_core_err", 32'(core_err), 32'd0);
      chk("rst_mid_dma_ack", 32'(dma_ack), 32'd0);
      chk("rst_mid_busy", 32'(core_busy), 32'd1);
      reset     = 1'b0;
      ack_delay = 2;
      push(1'b0, 1'b0, 8'h80, 8'h00, pat(8'h80), 1'b0);
      push(1'b1, 1'b0, 8'hA0, 8'h00, pat(8'hA0), 1'b0);
      serve_one(nreq, who, cyc);
      chk("delay2_req_cycles", 32'(nreq), 32'd3);
      core_read = 1'b0;
      serve_one(nreq, who, cyc);
      dma_req = 1'b0;
      @(negedge clock);

      // Read and write together is a write
      ack_delay  = 0;
      core_read  = 1'b1;
      core_write = 1'b1;
      core_addr  = 8'hB0;
      core_wdata = 8'h77;
      push(1'b0, 1'b1, 8'hB0, 8'h77, 8'h00, 1'b0);
      serve_one(nreq, who, cyc);
      core_read  = 1'b0;
      core_write = 1'b0;
      repeat (2) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
